// File: rtl/pulse_stretcher_pkg.sv
// Shared definitions for the pulse stretcher.
//   state_e  : controller states. IDLE=0, HIGH=1, LOW=2; the encoding 3 is
//              illegal and the controller recovers from it to IDLE.
//   ps_max   : larger of two non-negative integers.
//   ps_clog2 : ceiling log2, used to size the counter and pending-count widths.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  function automatic int unsigned ps_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned ps_clog2(input int unsigned v);
    int unsigned w;
    w = 0;
    while ((64'd1 << w) < 64'(v)) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/pulse_stretcher_edge_detect.sv
// Registered rising-edge detector.
//   i_clock   : clock, rising edge.
//   i_reset_n : asynchronous active-low reset; clears the history register.
//   i_level   : level to watch.
//   o_rise    : high in any cycle where i_level is high and was low (or in
//               reset) on the previous clock edge.
// A level already high when reset releases reports one rise, because the
// history register comes out of reset at 0.
module pulse_stretcher_edge_detect (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_level,
  output logic o_rise
);

  logic level_q;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      level_q <= 1'b0;
    end else begin
      level_q <= i_level;
    end
  end

  assign o_rise = i_level & ~level_q;

endmodule

// File: rtl/pulse_stretcher.sv
// Pulse stretcher: each rising edge on i_event produces one o_pulse of
// HIGH_CYCLES cycles, followed by at least LOW_CYCLES low cycles. Edges that
// arrive while a pulse or its gap is running are counted and replayed later.
//   i_clock    : clock, rising edge.
//   i_reset_n  : asynchronous active-low reset.
//   i_event    : event request; each rising edge is one event.
//   o_pulse    : stretched pulse (registered).
//   o_busy     : high while the controller is not idle (registered).
//   o_pending  : number of queued edges not yet started (registered).
//   o_overflow : one-cycle strobe when an edge was dropped on a full queue.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int unsigned HIGH_CYCLES = 20,
  parameter int unsigned LOW_CYCLES  = 20,
  parameter int unsigned MAX_PENDING = 7,
  localparam int unsigned PW = ps_clog2(MAX_PENDING + 1)
) (
  input  logic          i_clock,
  input  logic          i_reset_n,
  input  logic          i_event,
  output logic          o_pulse,
  output logic          o_busy,
  output logic [PW-1:0] o_pending,
  output logic          o_overflow
);

  localparam int unsigned CW = ps_clog2(ps_max(HIGH_CYCLES, LOW_CYCLES) + 1);
  localparam logic [CW-1:0] HIGH_LOAD = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] LOW_LOAD  = CW'(LOW_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PENDING);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pend_q, pend_d;
  logic          pulse_q, pulse_d;
  logic          busy_q, busy_d;
  logic          ovf_q, ovf_d;
  logic          evt_rise;

  pulse_stretcher_edge_detect u_edge (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_level   (i_event),
    .o_rise    (evt_rise)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ovf_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        pend_d = '0;
        if (evt_rise) begin
          state_d = ST_HIGH;
          cnt_d   = HIGH_LOAD;
        end
      end

      ST_HIGH: begin
        if (cnt_q == '0) begin
          state_d = ST_LOW;
          cnt_d   = LOW_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
        if (evt_rise) begin
          if (pend_q == PEND_MAX) begin
            ovf_d = 1'b1;
          end else begin
            pend_d = pend_q + PW'(1);
          end
        end
      end

      ST_LOW: begin
        if (cnt_q == '0) begin
          // End of gap: a queued edge starts the next pulse and frees its slot
          // before any coincident edge is queued, so a full queue cannot
          // overflow here and the count is net unchanged. With nothing queued
          // a coincident edge starts the pulse directly.
          if (pend_q != '0) begin
            state_d = ST_HIGH;
            cnt_d   = HIGH_LOAD;
            if (!evt_rise) begin
              pend_d = pend_q - PW'(1);
            end
          end else if (evt_rise) begin
            state_d = ST_HIGH;
            cnt_d   = HIGH_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (evt_rise) begin
            if (pend_q == PEND_MAX) begin
              ovf_d = 1'b1;
            end else begin
              pend_d = pend_q + PW'(1);
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        pend_d  = '0;
      end
    endcase

    // Outputs are registered copies of next-state decodes, so they change on
    // the same clock edge as the state.
    pulse_d = (state_d == ST_HIGH);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_pulse    = pulse_q;
  assign o_busy     = busy_q;
  assign o_pending  = pend_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
module tb_pulse_stretcher;

  localparam int H    = 4;
  localparam int L    = 3;
  localparam int MAXP = 2;
  localparam int PW   = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ev;
  logic          pulse;
  logic          busy;
  logic [PW-1:0] pend;
  logic          ovf;

  always #5 clk = ~clk;

  pulse_stretcher #(
    .HIGH_CYCLES (H),
    .LOW_CYCLES  (L),
    .MAX_PENDING (MAXP)
  ) dut (
    .i_clock    (clk),
    .i_reset_n  (rst_n),
    .i_event    (ev),
    .o_pulse    (pulse),
    .o_busy     (busy),
    .o_pending  (pend),
    .o_overflow (ovf)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Timeline reference: a pulse started after cycle t is high for cycles
  // t+1..t+H and the block stays busy through the last gap cycle t+H+L.
  int   cyc = 0;
  int   m_prev_ev;
  int   m_pend;
  int   m_busy_until;
  int   m_ps;
  bit   m_ovf;
  int   pulse_cnt;
  int   ovf_cnt;
  logic prev_pulse;

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_prev_ev    = 0;
    m_pend       = 0;
    m_busy_until = cyc - 1;
    m_ps         = -1000;
    m_ovf        = 0;
    prev_pulse   = 1'b0;
  endtask

  task automatic model_start();
    m_ps         = cyc + 1;
    m_busy_until = cyc + H + L;
  endtask

  task automatic model_update(input logic e);
    bit rise;
    rise      = (e == 1'b1) && (m_prev_ev == 0);
    m_prev_ev = (e == 1'b1) ? 1 : 0;
    m_ovf     = 0;
    if (cyc >= m_busy_until) begin
      if (m_pend > 0) begin
        model_start();
        m_pend = m_pend - 1;
        if (rise) m_pend = m_pend + 1;
      end else if (rise) begin
        model_start();
      end
    end else if (rise) begin
      if (m_pend < MAXP) m_pend = m_pend + 1;
      else m_ovf = 1;
    end
    cyc++;
  endtask

  task automatic check_outputs();
    chk("pulse", 32'(pulse), (cyc >= m_ps && cyc < m_ps + H) ? 1 : 0);
    chk("busy", 32'(busy), (cyc <= m_busy_until) ? 1 : 0);
    chk("pending", 32'(pend), m_pend);
    chk("overflow", 32'(ovf), m_ovf ? 1 : 0);
    if (pulse === 1'b1 && prev_pulse !== 1'b1) pulse_cnt++;
    if (ovf === 1'b1) ovf_cnt++;
    prev_pulse = pulse;
  endtask

  // Called at posedge+1; leaves at the next posedge+1.
  task automatic step(input logic e);
    ev = e;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #1;
    model_update(e);
  endtask

  task automatic apply_reset(input logic e_hold);
    #1;
    rst_n = 1'b0;
    ev    = e_hold;
    #1;
    chk("rst_pulse", 32'(pulse), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pending", 32'(pend), 0);
    chk("rst_overflow", 32'(ovf), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic scen_begin();
    pulse_cnt = 0;
    ovf_cnt   = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    ev    = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_pulse", 32'(pulse), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_pending", 32'(pend), 0);
    chk("reset_overflow", 32'(ovf), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // single one-cycle event
    scen_begin();
    for (int i = 0; i < 30; i++) step(i == 10);
    chk("t1_pulses", pulse_cnt, 1);

    // long level
    scen_begin();
    for (int i = 0; i < 50; i++) step(1'b1);
    for (int i = 0; i < 30; i++) step(1'b0);
    chk("t2_pulses", pulse_cnt, 1);

    // three queued edges
    scen_begin();
    for (int i = 0; i < 40; i++) step(i == 10 || i == 12 || i == 14);
    chk("t3_pulses", pulse_cnt, 3);
    chk("t3_ovf", ovf_cnt, 0);

    // fourth edge overflows a full queue
    scen_begin();
    for (int i = 0; i < 45; i++) step(i == 10 || i == 12 || i == 14 || i == 16);
    chk("t4_pulses", pulse_cnt, 3);
    chk("t4_ovf", ovf_cnt, 1);

    // edge on the last gap cycle
    scen_begin();
    for (int i = 0; i < 35; i++) step(i == 10 || i == 17);
    chk("t5_pulses", pulse_cnt, 2);

    // reset mid-pulse with a full queue
    for (int i = 0; i <= 20; i++) step(i == 10 || i == 12 || i == 14 || i == 19);
    chk("t6_pend_pre", 32'(pend), 2);
    chk("t6_pulse_pre", 32'(pulse), 1);
    apply_reset(1'b0);
    scen_begin();
    for (int i = 0; i < 20; i++) step(1'b0);
    chk("t6_pulses", pulse_cnt, 0);

    // event already high when reset releases
    apply_reset(1'b1);
    scen_begin();
    for (int i = 0; i < 20; i++) step(1'b1);
    for (int i = 0; i < 10; i++) step(1'b0);
    chk("t7_pulses", pulse_cnt, 1);

    // randomized runs of varying event density and run length
    for (int blk = 0; blk < 8; blk++) begin
      int   maxrun;
      int   left;
      logic cur;
      maxrun = 1 + blk * 3;
      left   = 0;
      cur    = 1'b0;
      for (int i = 0; i < 400; i++) begin
        if (left == 0) begin
          cur  = ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0;
          left = $urandom_range(1, maxrun);
        end
        left--;
        if ($urandom_range(0, 299) == 0) apply_reset(logic'($urandom_range(0, 1)));
        step(cur);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
